// File: rtl/dmi_dtm_dr.sv
// JTAG DTM data registers: DTMCS and DMI shift registers plus the DMI request/response
// handshake FSM with sticky error tracking, all clocked on TCK.
module dmi_dtm_dr #(
    parameter int unsigned AbitsWidth = 7,
    parameter int unsigned IdleCycles = 1
) (
    input  logic                  tck_i,
    input  logic                  trst_ni,
    input  logic                  dmi_clear_i,
    input  logic                  capture_i,
    input  logic                  shift_i,
    input  logic                  update_i,
    input  logic                  tdi_i,
    input  logic                  dtmcs_select_i,
    input  logic                  dmi_select_i,
    output logic                  dtmcs_tdo_o,
    output logic                  dmi_tdo_o,
    output logic                  dmi_req_valid_o,
    input  logic                  dmi_req_ready_i,
    output logic [AbitsWidth-1:0] dmi_req_addr_o,
    output logic [31:0]           dmi_req_data_o,
    output logic [1:0]            dmi_req_op_o,
    input  logic                  dmi_resp_valid_i,
    output logic                  dmi_resp_ready_o,
    input  logic [31:0]           dmi_resp_data_i,
    input  logic [1:0]            dmi_resp_resp_i,
    output logic                  dmi_rst_no
);

    localparam int unsigned DmiWidth = AbitsWidth + 34;
    localparam logic [2:0] IdleVal  = 3'(IdleCycles);
    localparam logic [5:0] AbitsVal = 6'(AbitsWidth);

    localparam logic [1:0] OpRead  = 2'd1;
    localparam logic [1:0] OpWrite = 2'd2;
    localparam logic [1:0] ErrFailed = 2'd2;
    localparam logic [1:0] ErrBusy   = 2'd3;

    typedef enum logic [2:0] {StIdle, StRead, StWaitRead, StWrite, StWaitWrite} state_e;

    state_e                state_q;
    logic [31:0]           dtmcs_sr_q;
    logic [DmiWidth-1:0]   dmi_sr_q;
    logic [1:0]            error_q;
    logic [AbitsWidth-1:0] addr_q;
    logic [31:0]           data_q;
    logic                  dmi_rst_nq;

    logic [31:0]           dtmcs_capture;
    logic [1:0]            dmi_status;
    logic [1:0]            upd_op;
    logic [31:0]           upd_data;
    logic [AbitsWidth-1:0] upd_addr;
    logic                  dtmcs_upd;
    logic                  dmi_upd;
    logic                  busy_evt;
    logic                  resp_err;

    assign dtmcs_capture = {14'd0, 2'd0, 1'b0, IdleVal, error_q, AbitsVal, 4'd1};

    assign upd_op   = dmi_sr_q[1:0];
    assign upd_data = dmi_sr_q[33:2];
    assign upd_addr = dmi_sr_q[DmiWidth-1:34];

    assign dtmcs_upd = update_i & dtmcs_select_i;
    assign dmi_upd   = update_i & dmi_select_i;
    // Touching the DMI register while a transaction is in flight is the busy condition.
    assign busy_evt  = (capture_i | update_i) & dmi_select_i & (state_q != StIdle)
                       & (error_q == 2'd0);
    assign resp_err  = (dmi_resp_resp_i != 2'd0) & (error_q == 2'd0);

    always_comb begin
        dmi_status = 2'd0;
        if (error_q != 2'd0) begin
            dmi_status = error_q;
        end else if (state_q != StIdle) begin
            dmi_status = ErrBusy;
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q    <= StIdle;
            dtmcs_sr_q <= '0;
            dmi_sr_q   <= '0;
            error_q    <= 2'd0;
            addr_q     <= '0;
            data_q     <= '0;
            dmi_rst_nq <= 1'b1;
        end else begin
            dmi_rst_nq <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (dmi_upd && error_q == 2'd0) begin
                        if (upd_op == OpRead) begin
                            addr_q  <= upd_addr;
                            state_q <= StRead;
                        end else if (upd_op == OpWrite) begin
                            addr_q  <= upd_addr;
                            data_q  <= upd_data;
                            state_q <= StWrite;
                        end
                    end
                end
                StRead: if (dmi_req_ready_i) state_q <= StWaitRead;
                StWrite: if (dmi_req_ready_i) state_q <= StWaitWrite;
                StWaitRead: begin
                    if (dmi_resp_valid_i) begin
                        data_q  <= dmi_resp_data_i;
                        state_q <= StIdle;
                        if (resp_err) error_q <= ErrFailed;
                    end
                end
                StWaitWrite: begin
                    if (dmi_resp_valid_i) begin
                        state_q <= StIdle;
                        if (resp_err) error_q <= ErrFailed;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Placed after the FSM so busy overrides a same-cycle failed response.
            if (busy_evt) error_q <= ErrBusy;

            if (capture_i && dtmcs_select_i) begin
                dtmcs_sr_q <= dtmcs_capture;
            end else if (shift_i && dtmcs_select_i) begin
                dtmcs_sr_q <= {tdi_i, dtmcs_sr_q[31:1]};
            end

            if (capture_i && dmi_select_i) begin
                dmi_sr_q <= {addr_q, data_q, dmi_status};
            end else if (shift_i && dmi_select_i) begin
                dmi_sr_q <= {tdi_i, dmi_sr_q[DmiWidth-1:1]};
            end

            if (dtmcs_upd && dtmcs_sr_q[16]) error_q <= 2'd0;
            if (dtmcs_upd && dtmcs_sr_q[17]) begin
                state_q    <= StIdle;
                error_q    <= 2'd0;
                addr_q     <= '0;
                data_q     <= '0;
                dmi_rst_nq <= 1'b0;
            end

            if (dmi_clear_i) begin
                state_q    <= StIdle;
                error_q    <= 2'd0;
                addr_q     <= '0;
                data_q     <= '0;
                dtmcs_sr_q <= '0;
                dmi_sr_q   <= '0;
                dmi_rst_nq <= 1'b1;
            end
        end
    end

    always_comb begin
        dmi_req_valid_o  = 1'b0;
        dmi_req_op_o     = 2'd0;
        dmi_resp_ready_o = 1'b0;
        unique case (state_q)
            StRead: begin
                dmi_req_valid_o = 1'b1;
                dmi_req_op_o    = OpRead;
            end
            StWrite: begin
                dmi_req_valid_o = 1'b1;
                dmi_req_op_o    = OpWrite;
            end
            StWaitRead, StWaitWrite: dmi_resp_ready_o = 1'b1;
            default: ;
        endcase
    end

    assign dmi_req_addr_o = addr_q;
    assign dmi_req_data_o = data_q;
    assign dmi_rst_no     = dmi_rst_nq;
    assign dtmcs_tdo_o    = dtmcs_sr_q[0];
    assign dmi_tdo_o      = dmi_sr_q[0];

endmodule

// File: doc/dmi_dtm_dr.md
DMI_DTM_DR -- requirements
Module: dmi_dtm_dr

Interface
REQ-001 SHALL have parameter AbitsWidth, default 7, meaning the DMI address width, range 1..63.
REQ-002 SHALL have parameter IdleCycles, default 1, meaning the 3-bit value reported in dtmcs.idle.
REQ-003 SHALL have port tck_i, input, 1 bit: JTAG test clock; all state is on its rising edge.
REQ-004 SHALL have port trst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port dmi_clear_i, input, 1 bit: TAP in Test-Logic-Reset (synchronous clear).
REQ-006 SHALL have ports capture_i, shift_i and update_i, input, 1 bit each: TAP Capture-DR, Shift-DR and Update-DR state strobes.
REQ-007 SHALL have port tdi_i, input, 1 bit: serial data in.
REQ-008 SHALL have ports dtmcs_select_i and dmi_select_i, input, 1 bit each: the IR selects DTMCS or DMI.
REQ-009 SHALL have ports dtmcs_tdo_o and dmi_tdo_o, output, 1 bit each: serial out, equal to bit 0 of the respective shift register.
REQ-010 SHALL have port dmi_req_valid_o, output, 1 bit, and port dmi_req_ready_i, input, 1 bit: request handshake.
REQ-011 SHALL have ports dmi_req_addr_o (AbitsWidth), dmi_req_data_o (32) and dmi_req_op_o (2), output: request payload; op 1 is read, op 2 is write.
REQ-012 SHALL have port dmi_resp_valid_i, input, 1 bit, and port dmi_resp_ready_o, output, 1 bit: response handshake.
REQ-013 SHALL have ports dmi_resp_data_i (32) and dmi_resp_resp_i (2), input: response payload; resp 0 means OK.
REQ-014 SHALL have port dmi_rst_no, output, 1 bit: active-low DMI hard-reset pulse.

Function
REQ-015 DTMCS capture value SHALL be: [31:18]=0, [17:16]=0, [15]=0, [14:12]=IdleCycles, [11:10]=error_q, [9:4]=AbitsWidth, [3:0]=1.
REQ-016 When capture_i and dtmcs_select_i are both high, the DTMCS shift register SHALL load the DTMCS capture value.
REQ-017 When shift_i and dtmcs_select_i are both high, the DTMCS shift register SHALL shift as {tdi_i, sr[31:1]}.
REQ-018 On update_i with dtmcs_select_i high, bit 16 set (dmireset) SHALL clear error_q to 0.
REQ-019 On update_i with dtmcs_select_i high, bit 17 set (dmihardreset) SHALL force the FSM to Idle, clear error_q, clear addr_q and data_q, and drive dmi_rst_no low for exactly 1 cycle.
REQ-020 The DMI shift register SHALL be AbitsWidth+34 bits with layout {addr, data[31:0], op[1:0]}; it captures {addr_q, data_q, status} and shifts LSB-first, in the same manner as DTMCS.
REQ-021 Capture status SHALL be: error_q if error_q is nonzero; otherwise 3 (busy) if the FSM is not in Idle; otherwise 0.
REQ-022 FSM states SHALL be Idle, Read, WaitRead, Write and WaitWrite.
REQ-023 From Idle, on update_i with dmi_select_i high and error_q=0: op 1 SHALL latch addr_q and go to Read; op 2 SHALL latch addr_q and data_q and go to Write; op 0 or 3 SHALL be a no-op.
REQ-024 In Read and Write, the block SHALL drive dmi_req_valid_o=1 with addr_q, data_q and the matching op; on dmi_req_ready_i it SHALL move to WaitRead or WaitWrite respectively.
REQ-025 Payload and dmi_req_valid_o SHALL be held stable until dmi_req_ready_i is sampled high.
REQ-026 In WaitRead and WaitWrite, the block SHALL drive dmi_resp_ready_o=1; on dmi_resp_valid_i it SHALL return to Idle.
REQ-027 On a response in WaitRead, data_q SHALL take dmi_resp_data_i; in WaitWrite, response data SHALL be discarded.
REQ-028 A response with nonzero resp and error_q=0 SHALL set error_q to 2 (failed).
REQ-029 capture_i or update_i with dmi_select_i high while the FSM is not Idle and error_q=0 SHALL set error_q to 3 (busy); that update SHALL NOT launch a request.
REQ-030 error_q SHALL be sticky; only a dmireset, a dmihardreset, dmi_clear_i or reset clears it.
REQ-031 When a busy event and a response occur in the same cycle, busy SHALL win for error_q while the response still completes.
REQ-032 dmi_clear_i SHALL act as dmihardreset except that it SHALL NOT pulse dmi_rst_no; it also clears both shift registers.
REQ-033 Outputs in Idle SHALL be: dmi_req_valid_o=0 and dmi_resp_ready_o=0.
REQ-034 Every strobe SHALL be ignored when neither select is high.

Reset
REQ-035 While trst_ni is low, the FSM SHALL be Idle, all registers 0, dmi_req_valid_o=0, dmi_resp_ready_o=0, both tdo outputs=0 and dmi_rst_no=1.
REQ-036 Reset asserted mid-handshake SHALL abort the transaction immediately with no completion.

Verification
REQ-037 Capture and shift 32 bits of DTMCS -> read 0x00001071 (AbitsWidth=7, IdleCycles=1, error 0).
REQ-038 DMI write addr 0x10, data 0xDEADBEEF with ready high -> 1 req cycle with op=2, then resp accepted, then Idle; next capture status=0.
REQ-039 DMI read addr 0x04 with response 0x12345678 -> next DMI capture shifts out data 0x12345678 with status 0.
REQ-040 Issue an update while in WaitRead -> error_q=3; subsequent updates launch nothing; DTMCS dmireset -> error_q=0.
REQ-041 Response with resp=2 -> capture status 2; DTMCS bit 17 while dmi_req_valid_o=1 -> FSM Idle, valid low next cycle, dmi_rst_no low for 1 cycle.
REQ-042 trst_ni asserted during WaitWrite -> all outputs at reset values asynchronously.
